// File: rtl/sync_frame_scheduler.sv
// sync_frame_scheduler: shares the master's byte transmitter between 4-byte
// time-sync frames (header, sequence, second, checksum) launched by the 1 Hz
// tick and single-byte command requests. Sync frames always win arbitration.
module sync_frame_scheduler #(
    parameter logic [7:0]  HEADER         = 8'hAA,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk_10M,
    input  logic       rst,
    input  logic       hz_tick,
    input  logic [7:0] time_second,
    input  logic       cmd_req,
    input  logic [7:0] cmd_data,
    output logic       cmd_ack,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    output logic       syn_en,
    output logic [7:0] frame_seq,
    output logic       busy,
    output logic       sync_pending,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int unsigned MAX_COUNT = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAX_COUNT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

    state_t        state_reg;
    logic [7:0]    frame_bytes_reg [4];
    logic [1:0]    byte_idx_reg;
    logic [1:0]    last_idx_reg;
    logic          is_sync_reg;
    logic [CW-1:0] cnt_reg;
    logic [7:0]    snapshot_reg;
    logic [7:0]    frame_seq_reg;
    logic [7:0]    tx_data_reg;
    logic          tx_start_reg;
    logic          syn_en_reg;
    logic          cmd_ack_reg;
    logic          sync_pending_reg;
    logic          overrun_reg;
    logic          timeout_err_reg;

    // Frame sequencer plus tick latch; the tick latch is evaluated last so a
    // tick in the same cycle a sync frame starts keeps sync_pending set.
    always_ff @(posedge clk_10M) begin
        if (rst) begin
            state_reg        <= IDLE;
            for (int i = 0; i < 4; i++) begin
                frame_bytes_reg[i] <= 8'h00;
            end
            byte_idx_reg     <= 2'd0;
            last_idx_reg     <= 2'd0;
            is_sync_reg      <= 1'b0;
            cnt_reg          <= '0;
            snapshot_reg     <= 8'h00;
            frame_seq_reg    <= 8'h00;
            tx_data_reg      <= 8'h00;
            tx_start_reg     <= 1'b0;
            syn_en_reg       <= 1'b0;
            cmd_ack_reg      <= 1'b0;
            sync_pending_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            timeout_err_reg  <= 1'b0;
        end else begin
            tx_start_reg <= 1'b0;
            syn_en_reg   <= 1'b0;
            cmd_ack_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (sync_pending_reg) begin
                        frame_bytes_reg[0] <= HEADER;
                        frame_bytes_reg[1] <= frame_seq_reg;
                        frame_bytes_reg[2] <= snapshot_reg;
                        frame_bytes_reg[3] <= HEADER ^ frame_seq_reg ^ snapshot_reg;
                        is_sync_reg        <= 1'b1;
                        byte_idx_reg       <= 2'd0;
                        last_idx_reg       <= 2'd3;
                        tx_data_reg        <= HEADER;
                        tx_start_reg       <= 1'b1;
                        syn_en_reg         <= 1'b1;
                        sync_pending_reg   <= 1'b0;
                        state_reg          <= LOAD;
                    end else if (cmd_req && !hz_tick) begin
                        // A tick arriving together with a command is only
                        // visible as pending next cycle, so the command
                        // defers one cycle to let the sync frame go first.
                        frame_bytes_reg[0] <= cmd_data;
                        is_sync_reg        <= 1'b0;
                        byte_idx_reg       <= 2'd0;
                        last_idx_reg       <= 2'd0;
                        tx_data_reg        <= cmd_data;
                        tx_start_reg       <= 1'b1;
                        cmd_ack_reg        <= 1'b1;
                        state_reg          <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_reg   <= CW'(1);
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (is_sync_reg && byte_idx_reg == 2'd3) begin
                            frame_seq_reg <= frame_seq_reg + 8'd1;
                        end
                        cnt_reg   <= CW'(1);
                        state_reg <= GAP;
                    end else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: marking the current byte as the last one
                        // makes the gap return to IDLE.
                        timeout_err_reg <= 1'b1;
                        last_idx_reg    <= byte_idx_reg;
                        cnt_reg         <= CW'(1);
                        state_reg       <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == CW'(GAP_CYCLES)) begin
                        if (byte_idx_reg != last_idx_reg) begin
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            tx_data_reg  <= frame_bytes_reg[byte_idx_reg + 2'd1];
                            tx_start_reg <= 1'b1;
                            state_reg    <= LOAD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (hz_tick) begin
                sync_pending_reg <= 1'b1;
                snapshot_reg     <= time_second;
                if (sync_pending_reg) begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    assign cmd_ack      = cmd_ack_reg;
    assign tx_data      = tx_data_reg;
    assign tx_start     = tx_start_reg;
    assign syn_en       = syn_en_reg;
    assign frame_seq    = frame_seq_reg;
    assign busy         = (state_reg != IDLE);
    assign sync_pending = sync_pending_reg;
    assign overrun      = overrun_reg;
    assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_sync_frame_scheduler.sv
// Testbench for sync_frame_scheduler: scoreboard of expected transmitted
// bytes, an auto-responding transmitter model and directed scenarios.
module tb_sync_frame_scheduler;

    localparam int TB_GAP     = 8;
    localparam int TB_TIMEOUT = 100;

    logic       clk_10M = 1'b0;
    logic       rst;
    logic       hz_tick;
    logic [7:0] time_second;
    logic       cmd_req;
    logic [7:0] cmd_data;
    logic       cmd_ack;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       syn_en;
    logic [7:0] frame_seq;
    logic       busy;
    logic       sync_pending;
    logic       overrun;
    logic       timeout_err;

    sync_frame_scheduler #(
        .HEADER        (8'hAA),
        .GAP_CYCLES    (TB_GAP),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk_10M     (clk_10M),
        .rst         (rst),
        .hz_tick     (hz_tick),
        .time_second (time_second),
        .cmd_req     (cmd_req),
        .cmd_data    (cmd_data),
        .cmd_ack     (cmd_ack),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .syn_en      (syn_en),
        .frame_seq   (frame_seq),
        .busy        (busy),
        .sync_pending(sync_pending),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #50 clk_10M = ~clk_10M;

    typedef struct packed {
        logic [7:0] data;
        logic       syn;
        logic       ack;
        logic       first;
    } exp_t;

    exp_t       sbq [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         last_done_cyc = 0;
    int         byte_count = 0;
    int         resp_delay = 20;
    bit         resp_drop  = 1'b0;
    logic [7:0] model_seq  = 8'h00;

    always @(posedge clk_10M) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_sync(input logic [7:0] sec);
        sbq.push_back('{data: 8'hAA, syn: 1'b1, ack: 1'b0, first: 1'b1});
        sbq.push_back('{data: model_seq, syn: 1'b0, ack: 1'b0, first: 1'b0});
        sbq.push_back('{data: sec, syn: 1'b0, ack: 1'b0, first: 1'b0});
        sbq.push_back('{data: 8'hAA ^ model_seq ^ sec, syn: 1'b0, ack: 1'b0, first: 1'b0});
        model_seq = model_seq + 8'd1;
    endtask

    task automatic push_cmd(input logic [7:0] d);
        sbq.push_back('{data: d, syn: 1'b0, ack: 1'b1, first: 1'b1});
    endtask

    // Drives a one-cycle tick; returns just after the edge that sampled it.
    task automatic tick(input logic [7:0] sec);
        time_second = sec;
        hz_tick = 1'b1;
        @(posedge clk_10M); #1;
        hz_tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_10M); #1;
            if (!busy && !sync_pending && sbq.size() == 0) return;
        end
        check("wait_idle_busy", busy, 0);
        check("wait_idle_queue", sbq.size(), 0);
    endtask

    task automatic wait_ack(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_10M); #1;
            if (cmd_ack) begin
                cmd_req = 1'b0;
                return;
            end
        end
        check("wait_ack", cmd_ack, 1);
        cmd_req = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_10M); #1;
            if (tx_start) seen++;
            if (seen == n) return;
        end
        check("wait_starts", seen, n);
    endtask

    // Transmitter model: answers each tx_start with a tx_done pulse.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk_10M); #1;
            if (tx_start && !rst && !resp_drop) begin
                repeat (resp_delay) @(posedge clk_10M);
                #1 tx_done = 1'b1;
                @(posedge clk_10M); #1;
                tx_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: compares every issued byte against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_10M);
            if (tx_done) last_done_cyc = cyc;
            if (!tx_start && (syn_en || cmd_ack))
                check("stray_pulse", {syn_en, cmd_ack}, 0);
            if (tx_start) begin
                byte_count++;
                if (sbq.size() == 0) begin
                    check("unexpected_start", tx_data, 0);
                    check("unexpected_start_q", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    $display("byte %0d: data=%02h syn_en=%0b cmd_ack=%0b (exp %02h %0b %0b)",
                             byte_count, tx_data, syn_en, cmd_ack, e.data, e.syn, e.ack);
                    check("tx_data", tx_data, e.data);
                    check("syn_en", syn_en, e.syn);
                    check("cmd_ack", cmd_ack, e.ack);
                    if (!e.first) check("gap_len", cyc - last_done_cyc, TB_GAP + 1);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        hz_tick = 1'b0;
        time_second = 8'h00;
        cmd_req = 1'b0;
        cmd_data = 8'h00;
        repeat (3) @(posedge clk_10M);
        #1;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_seq", frame_seq, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_pending", sync_pending, 0);
        rst = 1'b0;
        @(posedge clk_10M); #1;

        // 1: single sync frame, latency and gap
        resp_delay = 20;
        push_sync(8'h05);
        tick(8'h05);
        check("t1_pending", sync_pending, 1);
        check("t1_no_start_yet", tx_start, 0);
        @(posedge clk_10M); #1;
        check("t1_start", tx_start, 1);
        check("t1_syn_en", syn_en, 1);
        check("t1_pending_clr", sync_pending, 0);
        wait_idle(2000);
        check("t1_frame_seq", frame_seq, model_seq);

        // 2: tick and command together, sync first
        push_sync(8'h11);
        push_cmd(8'h3C);
        cmd_data = 8'h3C;
        cmd_req = 1'b1;
        tick(8'h11);
        wait_ack(2000);
        wait_idle(2000);
        check("t2_frame_seq", frame_seq, model_seq);

        // 3: command held in WAIT, two ticks -> overrun, newest second sent once
        resp_delay = 60;
        push_cmd(8'h5A);
        push_sync(8'h08);
        cmd_data = 8'h5A;
        cmd_req = 1'b1;
        wait_ack(100);
        repeat (5) @(posedge clk_10M); #1;
        tick(8'h07);
        check("t3_no_overrun", overrun, 0);
        repeat (5) @(posedge clk_10M); #1;
        tick(8'h08);
        check("t3_overrun", overrun, 1);
        check("t3_busy", busy, 1);
        wait_idle(2000);
        check("t3_frame_seq", frame_seq, model_seq);
        resp_delay = 20;

        // 4: header never acknowledged -> timeout
        resp_drop = 1'b1;
        sbq.push_back('{data: 8'hAA, syn: 1'b1, ack: 1'b0, first: 1'b1});
        tick(8'h20);
        @(posedge clk_10M); #1;
        check("t4_start", tx_start, 1);
        repeat (TB_TIMEOUT - 1) @(posedge clk_10M);
        #1;
        check("t4_timeout_early", timeout_err, 0);
        @(posedge clk_10M); #1;
        check("t4_timeout", timeout_err, 1);
        resp_drop = 1'b0;
        wait_idle(2000);
        check("t4_seq_kept", frame_seq, model_seq);
        push_sync(8'h21);
        tick(8'h21);
        wait_idle(2000);
        check("t4_resend_seq", frame_seq, model_seq);

        // 5: 256 frames, sequence wraps through FF to 00
        resp_delay = 3;
        for (int i = 0; i < 256; i++) begin
            push_sync(8'(i) ^ 8'h5A);
            tick(8'(i) ^ 8'h5A);
            wait_idle(500);
        end
        check("t5_frame_seq", frame_seq, model_seq);
        push_sync(8'h77);
        tick(8'h77);
        wait_idle(500);
        check("t5_after_wrap", frame_seq, model_seq);

        // 6: reset during WAIT of byte 2
        resp_delay = 20;
        sbq.push_back('{data: 8'hAA, syn: 1'b1, ack: 1'b0, first: 1'b1});
        sbq.push_back('{data: model_seq, syn: 1'b0, ack: 1'b0, first: 1'b0});
        sbq.push_back('{data: 8'h30, syn: 1'b0, ack: 1'b0, first: 1'b0});
        tick(8'h30);
        wait_starts(3, 2000);
        repeat (2) @(posedge clk_10M); #1;
        rst = 1'b1;
        @(posedge clk_10M); #1;
        check("t6_tx_start", tx_start, 0);
        check("t6_tx_data", tx_data, 0);
        check("t6_busy", busy, 0);
        check("t6_frame_seq", frame_seq, 0);
        check("t6_overrun", overrun, 0);
        check("t6_timeout", timeout_err, 0);
        rst = 1'b0;
        model_seq = 8'h00;
        repeat (40) @(posedge clk_10M); #1;
        check("t6_idle_after", busy, 0);
        check("t6_queue_drained", sbq.size(), 0);
        push_sync(8'h31);
        tick(8'h31);
        wait_idle(2000);
        check("t6_clean_seq", frame_seq, model_seq);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
